// File: rtl/duck_pkg.sv
// Shared types and constants for the Duck Hunt light-gun path.
package duck_pkg;

  localparam int unsigned CNT_W = 16;

  // Literals carry a prefix because both enums share this package scope.
  typedef enum logic [1:0] {
    FLASH_NORMAL = 2'b00,
    FLASH_BLACK  = 2'b01,
    FLASH_TARGET = 2'b10
  } flash_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_BLACK    = 3'd2,
    ST_TARGET   = 3'd3,
    ST_EVAL     = 3'd4,
    ST_COOLDOWN = 3'd5
  } gun_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser, level debouncer and rising-edge pulse for one
// asynchronous, mechanically bouncing input.
module sync_debounce #(
  parameter int unsigned CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic rise_o
);

  localparam int unsigned CW   = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(CYCLES);

  logic          s1_q, s2_q;
  logic          acc_q, acc_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Bring the raw pin into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din_i;
      s2_q <= s1_q;
    end
  end

  // Accept a new level only after it has held CYCLES cycles; emit the 0->1 edge.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (s2_q == acc_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CMAX) begin
      acc_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    rise_d = acc_d & ~acc_q;
  end

  // Debounce state and registered edge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/gun_hit_detector.sv
// Light-gun front end: conditions trigger/photodiode, runs the black frame /
// target frame flash sequence on frame boundaries and issues hit or miss.
module gun_hit_detector
  import duck_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned DETECT_MIN      = 64,
  parameter int unsigned COOLDOWN_FRAMES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       valid,
  input  logic       trigger,
  input  logic       detect,
  output logic [1:0] flash_mode,
  output logic       hit,
  output logic       miss,
  output logic       busy
);

  localparam int unsigned COOL_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [COOL_W-1:0] COOL_MAX = COOL_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0]  DMIN     = CNT_W'(DETECT_MIN);

  logic              shot;
  logic              det_s1_q, det_s2_q;
  logic              det_s;

  gun_state_t        state_q, state_d;
  logic [CNT_W-1:0]  black_q, black_d;
  logic [CNT_W-1:0]  target_q, target_d;
  logic [COOL_W-1:0] cool_q, cool_d;
  logic [COOL_W-1:0] cool_inc;

  flash_mode_t       flash_q, flash_d;
  logic              hit_q, hit_d;
  logic              miss_q, miss_d;
  logic              busy_q, busy_d;

  sync_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_trig (
    .clk    (clk),
    .reset  (reset),
    .din_i  (trigger),
    .rise_o (shot)
  );

  // Photodiode needs only synchronising; it is sampled per pixel, not debounced.
  always_ff @(posedge clk) begin
    if (reset) begin
      det_s1_q <= 1'b0;
      det_s2_q <= 1'b0;
    end else begin
      det_s1_q <= detect;
      det_s2_q <= det_s1_q;
    end
  end

  assign det_s    = det_s2_q;
  assign cool_inc = cool_q + COOL_W'(frame_start);

  // Sequence next-state, light counters and the verdict decided as TARGET ends.
  always_comb begin
    state_d  = state_q;
    black_d  = black_q;
    target_d = target_q;
    cool_d   = cool_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (shot) state_d = ST_ARM;
      end
      ST_ARM: begin
        black_d  = '0;
        target_d = '0;
        if (frame_start) state_d = ST_BLACK;
      end
      ST_BLACK: begin
        if (valid && det_s) black_d = sat_inc(black_q);
        if (frame_start) state_d = ST_TARGET;
      end
      ST_TARGET: begin
        if (valid && det_s) target_d = sat_inc(target_q);
        if (frame_start) begin
          state_d = ST_EVAL;
          // Light during the black frame means a lamp, not the target.
          hit_d   = (target_d >= DMIN) && (black_q < DMIN);
          miss_d  = !hit_d;
        end
      end
      ST_EVAL: begin
        state_d = ST_COOLDOWN;
        cool_d  = '0;
      end
      ST_COOLDOWN: begin
        if (cool_inc >= COOL_MAX) begin
          state_d = ST_IDLE;
          cool_d  = '0;
        end else begin
          cool_d  = cool_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    flash_d = FLASH_NORMAL;
    if (state_d == ST_BLACK) begin
      flash_d = FLASH_BLACK;
    end else if (state_d == ST_TARGET) begin
      flash_d = FLASH_TARGET;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      black_q  <= '0;
      target_q <= '0;
      cool_q   <= '0;
      flash_q  <= FLASH_NORMAL;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      black_q  <= black_d;
      target_q <= target_d;
      cool_q   <= cool_d;
      flash_q  <= flash_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      busy_q   <= busy_d;
    end
  end

  assign flash_mode = flash_q;
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_gun_hit_detector.sv
// Bench for gun_hit_detector: 100-cycle frames, active video on cycles 10-89,
// frame_start on cycle 95. Verdicts go through a scoreboard queue.
module tb_gun_hit_detector;

  localparam int unsigned DEB  = 4;
  localparam int unsigned DMIN = 3;
  localparam int unsigned COOL = 2;

  logic       clk = 1'b0;
  logic       reset, frame_start, valid, trigger, detect;
  logic [1:0] flash_mode;
  logic       hit, miss, busy;

  int     pos;
  longint gcyc;
  int     n_tests = 0;
  int     n_fail  = 0;

  typedef struct {
    bit     hit;
    longint cyc;
  } verdict_t;

  verdict_t exp_q[$];

  gun_hit_detector #(
    .DEBOUNCE_CYCLES (DEB),
    .DETECT_MIN      (DMIN),
    .COOLDOWN_FRAMES (COOL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .valid       (valid),
    .trigger     (trigger),
    .detect      (detect),
    .flash_mode  (flash_mode),
    .hit         (hit),
    .miss        (miss),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Frame timing source.
  initial begin
    pos         = 99;
    gcyc        = 0;
    frame_start = 1'b0;
    valid       = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      gcyc++;
      pos         = (pos == 99) ? 0 : pos + 1;
      frame_start = (pos == 95);
      valid       = (pos >= 10 && pos <= 89);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, gcyc);
    end
  endtask

  task automatic wait_pos(input int p);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (pos != p && k < 300);
    if (pos != p) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_pos: got position %0d, expected %0d", pos, p);
    end
  endtask

  // Scoreboard consumer: every hit/miss pulse must match the oldest expectation.
  task automatic monitor();
    verdict_t e;
    forever begin
      @(negedge clk);
      if (hit === 1'b1 || miss === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL verdict_unexpected: got hit=%0b miss=%0b at cycle %0d, expected no pulse",
                   hit, miss, gcyc);
        end else begin
          e = exp_q.pop_front();
          if (hit !== e.hit || miss !== !e.hit || gcyc != e.cyc) begin
            n_fail++;
            $display("FAIL verdict: got hit=%0b miss=%0b at cycle %0d, expected hit=%0b miss=%0b at cycle %0d",
                     hit, miss, gcyc, e.hit, !e.hit, e.cyc);
          end
        end
      end
    end
  endtask

  // Drive one frame starting at position 96 and stopping at 95; returns the
  // number of active-video cycles the photodiode was lit.
  task automatic drive_frame(input int ws, input int n, input bit lamp, input bit trig_pulse,
                             output int seen);
    seen = 0;
    do begin
      detect = lamp || (pos >= ws && pos < ws + n);
      if (trig_pulse) trigger = (pos >= 10 && pos < 60);
      if (detect && valid) seen++;
      @(negedge clk);
    end while (pos != 95);
  endtask

  // One complete shot: trigger, black frame, target frame, verdict, cooldown.
  // drop: 0 none, 1 extra trigger in TARGET, 2 extra trigger in first cooldown frame.
  task automatic run_shot(input int bn, input int tn, input bit lamp, input int drop,
                          input bit bounce, input int ws);
    int sb, st, dummy;
    wait_pos(10);
    if (bounce) begin
      for (int i = 0; i < 20; i++) begin
        trigger = ((i / 2) % 2 == 0);
        @(negedge clk);
      end
      chk("busy_during_bounce", busy, 0);
    end else begin
      wait_pos(30);
    end
    trigger = 1'b1;
    for (int i = 0; i < 7; i++) @(negedge clk);
    chk("busy_before_shot", busy, 0);
    @(negedge clk);
    chk("busy_after_shot", busy, 1);

    wait_pos(95);
    chk("arm_flash", flash_mode, 0);
    @(negedge clk);
    chk("black_flash", flash_mode, 1);
    trigger = 1'b0;
    drive_frame(ws, bn, lamp, 1'b0, sb);
    chk("black_hold", flash_mode, 1);
    @(negedge clk);
    chk("target_flash", flash_mode, 2);
    drive_frame(ws, tn, lamp, drop == 1, st);
    exp_q.push_back('{hit: (st >= int'(DMIN) && sb < int'(DMIN)), cyc: gcyc + 1});
    detect = 1'b0;
    @(negedge clk);
    chk("eval_flash", flash_mode, 0);
    chk("eval_busy", busy, 1);

    drive_frame(0, 0, 1'b0, drop == 2, dummy);
    chk("cool1_busy", busy, 1);
    @(negedge clk);
    chk("cool1_after", busy, 1);
    drive_frame(0, 0, 1'b0, 1'b0, dummy);
    chk("cool2_busy", busy, 1);
    @(negedge clk);
    chk("cool_done_busy", busy, 0);
    chk("cool_done_flash", flash_mode, 0);
    drive_frame(0, 0, 1'b0, 1'b0, dummy);
    chk("idle_after", busy, 0);
  endtask

  // Reset pulse in the middle of a lit target frame must abort silently.
  task automatic reset_mid();
    int sb;
    wait_pos(10);
    wait_pos(30);
    trigger = 1'b1;
    wait_pos(95);
    @(negedge clk);
    trigger = 1'b0;
    drive_frame(20, 0, 1'b0, 1'b0, sb);
    @(negedge clk);
    chk("rst_target_flash", flash_mode, 2);
    wait_pos(20);
    detect = 1'b1;
    wait_pos(30);
    detect = 1'b0;
    wait_pos(50);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_flash", flash_mode, 0);
    chk("rst_busy", busy, 0);
    wait_pos(96);
    chk("rst_no_hit", hit, 0);
    chk("rst_no_miss", miss, 0);
    chk("rst_idle", busy, 0);
  endtask

  initial begin
    reset   = 1'b1;
    trigger = 1'b0;
    detect  = 1'b0;
    fork
      monitor();
    join_none
    repeat (5) @(negedge clk);
    chk("reset_flash", flash_mode, 0);
    chk("reset_hit", hit, 0);
    chk("reset_miss", miss, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", busy, 0);

    run_shot(0, 5, 1'b0, 0, 1'b1, 20);   // bounce rejection + clean hit
    run_shot(0, 3, 1'b0, 0, 1'b0, 25);   // target exactly at threshold
    run_shot(0, 2, 1'b0, 0, 1'b0, 25);   // one below threshold
    run_shot(3, 5, 1'b0, 0, 1'b0, 25);   // black exactly at threshold
    run_shot(2, 5, 1'b0, 0, 1'b0, 25);   // black just below threshold
    run_shot(0, 0, 1'b1, 0, 1'b0, 0);    // lamp cheat
    run_shot(0, 5, 1'b0, 1, 1'b0, 30);   // trigger during TARGET dropped
    run_shot(0, 1, 1'b0, 2, 1'b0, 30);   // trigger during COOLDOWN dropped
    reset_mid();
    for (int r = 0; r < 6; r++) begin
      run_shot(int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), 1'b0, 0, 1'b0,
               int'($urandom_range(15, 40)));
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
